// File: rtl/id_ex_skid_reg.sv
// id_ex_skid_reg: ID/EX stage as a two-entry FIFO skid buffer.
// Valid/ready on both sides; flush, bubble on empty.
//
// Ports:
//   clk, reset (async, active-low), flush (sync discard)
//   in_valid/in_ready        : decode-side handshake
//   *_en, branch, A_in, B_in,
//   sel, PC_n, rd            : decoded payload
//   rs1, rs2                 : sources, hazard check only
//   out_valid/out_ready      : execute-side handshake
//   *_n, A, B, alu_select,
//   PC_new, rd_n             : registered payload
//   stall                    : load-use hazard
//   occupancy                : entries held (0..2)
//
// Build option: define ID_EX_LOAD_USE_EN to enable
// load-use stalling; otherwise stall is tied 0.
module id_ex_skid_reg #(
  parameter int XLEN   = 32,
  parameter int SEL_W  = 4,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_read_en,
  input  logic              mem_write_en,
  input  logic              mem_to_reg_en,
  input  logic              jumpl_en,
  input  logic              branch,
  input  logic              reg_write_en,
  input  logic [XLEN-1:0]   A_in,
  input  logic [XLEN-1:0]   B_in,
  input  logic [SEL_W-1:0]  sel,
  input  logic [XLEN-1:0]   PC_n,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              mem_read_n,
  output logic              mem_write_n,
  output logic              mem_to_reg_n,
  output logic              jumpl_n,
  output logic              branch_n,
  output logic              reg_write_n,
  output logic [XLEN-1:0]   A,
  output logic [XLEN-1:0]   B,
  output logic [SEL_W-1:0]  alu_select,
  output logic [XLEN-1:0]   PC_new,
  output logic [REG_AW-1:0] rd_n,
  output logic              stall,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              jumpl;
    logic              branch;
    logic              reg_write;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [SEL_W-1:0]  sel;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rd;
  } id_ex_t;

  // State code doubles as the entry count.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_d;
  id_ex_t     in_e;
  id_ex_t     main_q;
  id_ex_t     main_d;
  id_ex_t     skid_q;
  id_ex_t     skid_d;
  logic       vld;
  logic       acc;
  logic       pop;

  always_comb begin
    in_e            = '0;
    in_e.mem_read   = mem_read_en;
    in_e.mem_write  = mem_write_en;
    in_e.mem_to_reg = mem_to_reg_en;
    in_e.jumpl      = jumpl_en;
    in_e.branch     = branch;
    in_e.reg_write  = reg_write_en;
    in_e.a          = A_in;
    in_e.b          = B_in;
    in_e.sel        = sel;
    in_e.pc         = PC_n;
    in_e.rd         = rd;
  end

  assign vld       = (state_q != EMPTY);
  assign out_valid = vld;
  assign occupancy = state_q;

`ifdef ID_EX_LOAD_USE_EN
  logic src_hit;
  assign src_hit  = (rd_n == rs1) | (rd_n == rs2);
  assign stall    = in_valid & vld & mem_read_n
                  & (rd_n != '0) & src_hit;
  assign in_ready = (state_q != TWO) & ~stall;
`else
  logic unused_rs;
  assign unused_rs = ^{rs1, rs2};
  assign stall     = 1'b0;
  assign in_ready  = (state_q != TWO);
`endif

  assign acc = in_valid & in_ready;
  assign pop = vld & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (1'b1)
      (state_q == EMPTY): begin
        if (acc) begin
          state_d = ONE;
          main_d  = in_e;
        end
      end
      (state_q == ONE): begin
        if (acc && !pop) begin
          state_d = TWO;
          skid_d  = in_e;
        end else if (acc && pop) begin
          main_d = in_e;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      (state_q == TWO): begin
        if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops everything, including a same-cycle accept.
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Control is gated so an empty stage is a bubble.
  assign mem_read_n   = main_q.mem_read   & vld;
  assign mem_write_n  = main_q.mem_write  & vld;
  assign mem_to_reg_n = main_q.mem_to_reg & vld;
  assign jumpl_n      = main_q.jumpl      & vld;
  assign branch_n     = main_q.branch     & vld;
  assign reg_write_n  = main_q.reg_write  & vld;
  assign A            = main_q.a;
  assign B            = main_q.b;
  assign alu_select   = main_q.sel;
  assign PC_new       = main_q.pc;
  assign rd_n         = main_q.rd;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// tb_id_ex_skid_reg: randomized + directed bench with
// a queue-based FIFO reference model and scoreboard.
module tb_id_ex_skid_reg;

  typedef struct packed {
    logic        mr;
    logic        mw;
    logic        mtr;
    logic        jl;
    logic        br;
    logic        rw;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [31:0] pc;
    logic [4:0]  rd;
  } pay_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  pay_t        din = '0;

  logic        in_ready;
  logic        out_valid;
  logic        mem_read_n;
  logic        mem_write_n;
  logic        mem_to_reg_n;
  logic        jumpl_n;
  logic        branch_n;
  logic        reg_write_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  alu_select;
  logic [31:0] PC_new;
  logic [4:0]  rd_n;
  logic        stall;
  logic [1:0]  occupancy;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  id_ex_skid_reg dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_read_en  (din.mr),
    .mem_write_en (din.mw),
    .mem_to_reg_en(din.mtr),
    .jumpl_en     (din.jl),
    .branch       (din.br),
    .reg_write_en (din.rw),
    .A_in         (din.a),
    .B_in         (din.b),
    .sel          (din.sel),
    .PC_n         (din.pc),
    .rd           (din.rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .mem_read_n   (mem_read_n),
    .mem_write_n  (mem_write_n),
    .mem_to_reg_n (mem_to_reg_n),
    .jumpl_n      (jumpl_n),
    .branch_n     (branch_n),
    .reg_write_n  (reg_write_n),
    .A            (A),
    .B            (B),
    .alu_select   (alu_select),
    .PC_new       (PC_new),
    .rd_n         (rd_n),
    .stall        (stall),
    .occupancy    (occupancy)
  );

  function automatic void chk(string nm,
                              logic [63:0] act,
                              logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endfunction

  // Reference model: an ordered list of held entries.
  pay_t q[$];
  pay_t last = '0;
  pay_t cur;
  pay_t pp;
  logic ev;
  logic st;
  logic ir;

  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      last = '0;
    end else begin
      ev  = (q.size() != 0);
      cur = ev ? q[0] : last;
`ifdef ID_EX_LOAD_USE_EN
      st = in_valid && ev && cur.mr && cur.rd != 0
        && (cur.rd == rs1 || cur.rd == rs2);
`else
      st = 1'b0;
`endif
      ir = (q.size() < 2) && !st;
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("in_ready", 64'(in_ready), 64'(ir));
      chk("occupancy", 64'(occupancy), 64'(q.size()));
      chk("stall", 64'(stall), 64'(st));
      chk("ctrl",
          64'({mem_read_n, mem_write_n, mem_to_reg_n,
               jumpl_n, branch_n, reg_write_n}),
          64'(ev ? {cur.mr, cur.mw, cur.mtr,
                    cur.jl, cur.br, cur.rw} : 6'b0));
      chk("A", 64'(A), 64'(cur.a));
      chk("B", 64'(B), 64'(cur.b));
      chk("alu_select", 64'(alu_select), 64'(cur.sel));
      chk("PC_new", 64'(PC_new), 64'(cur.pc));
      chk("rd_n", 64'(rd_n), 64'(cur.rd));
      if (ev && out_ready) begin
        pp = q.pop_front();
        if (q.size() == 0) last = pp;
      end
      if (flush) begin
        q.delete();
        last = '0;
      end else if (in_valid && ir) begin
        q.push_back(din);
      end
    end
  end

  function automatic pay_t mk(logic [5:0]  ctl,
                              logic [31:0] a,
                              logic [31:0] b,
                              logic [3:0]  s,
                              logic [31:0] pc,
                              logic [4:0]  r);
    pay_t p;
    p = {ctl, a, b, s, pc, r};
    return p;
  endfunction

  function automatic pay_t rnd();
    pay_t p;
    p = {6'($urandom), $urandom, $urandom,
         4'($urandom), $urandom,
         5'($urandom_range(0, 3))};
    return p;
  endfunction

  task automatic cyc(input logic iv, input logic ordy,
                     input logic fl, input pay_t p,
                     input logic [4:0] r1,
                     input logic [4:0] r2);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    din       = p;
    rs1       = r1;
    rs2       = r2;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_ctrl",
        64'({mem_read_n, mem_write_n, mem_to_reg_n,
             jumpl_n, branch_n, reg_write_n}), 64'd0);
    chk("rst_A", 64'(A), 64'd0);
    chk("rst_B", 64'(B), 64'd0);
    chk("rst_sel", 64'(alu_select), 64'd0);
    chk("rst_PC", 64'(PC_new), 64'd0);
    chk("rst_rd", 64'(rd_n), 64'd0);
  endtask

  pay_t nop;
  pay_t ld;
  pay_t dep;

  initial begin
    nop = '0;
    #1;
    chk_rst();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // add x3,x4,x5 stream, one per cycle
    for (int i = 0; i < 8; i++)
      cyc(1, 1, 0,
          mk(6'b000001, 32'(5 + i), 32'(7 + i), 4'b0000,
             32'h12 + 32'(4 * i), 5'd3), 5'd4, 5'd5);
    cyc(0, 1, 0, nop, 0, 0);
    cyc(0, 1, 0, nop, 0, 0);

    // back-pressure: third offer must be held
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 0,
          mk(6'b000001, 32'(100 + i), 32'(200 + i), 4'd2,
             32'h100 + 32'(4 * i), 5'(i + 1)), 0, 0);
    for (int i = 0; i < 5; i++)
      cyc(0, 1, 0, nop, 0, 0);

    // flush while full with an offer; then flush+pop+accept
    cyc(1, 0, 0, mk(6'b111111, 1, 2, 3, 4, 5), 0, 0);
    cyc(1, 0, 0, mk(6'b010010, 6, 7, 8, 9, 10), 0, 0);
    cyc(1, 0, 1, mk(6'b000001, 11, 12, 1, 13, 14), 0, 0);
    cyc(1, 0, 0, mk(6'b110101, 15, 16, 2, 17, 18), 0, 0);
    cyc(1, 1, 1, mk(6'b011011, 19, 20, 3, 21, 22), 0, 0);

    // bubbles
    cyc(0, 1, 0, nop, 0, 0);
    cyc(0, 1, 0, nop, 0, 0);

    // load x1 then dependent use of x1
    ld  = mk(6'b101001, 0, 32'h12, 4'd0, 32'h40, 5'd1);
    dep = mk(6'b000001, 3, 4, 4'd0, 32'h44, 5'd2);
    cyc(1, 0, 0, ld, 5'd2, 5'd0);
    cyc(1, 0, 0, dep, 5'd1, 5'd3);
    cyc(1, 0, 0, dep, 5'd1, 5'd3);
    cyc(1, 1, 0, dep, 5'd1, 5'd3);
    cyc(0, 1, 0, nop, 0, 0);
    cyc(0, 1, 0, nop, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 4) != 0, ($urandom % 3) != 0,
          ($urandom % 25) == 0, rnd(),
          5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)));

    // async reset with two entries held
    cyc(1, 0, 0, rnd(), 0, 0);
    cyc(1, 0, 0, rnd(), 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_rst();
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 40; i++)
      cyc(($urandom % 3) != 0, ($urandom % 2) != 0,
          1'b0, rnd(),
          5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)));
    cyc(0, 1, 0, nop, 0, 0);
    cyc(0, 1, 0, nop, 0, 0);
    cyc(0, 1, 0, nop, 0, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
